// File: rtl/coef_rom_arbiter_pkg.sv
// Shared types and constants for the DCT coefficient ROM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package coef_rom_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int MAX_NUM_REQ = 8;
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_ROM_LAT = 2;

  // The id field is sized for the largest legal requester count, so a
  // single tag type serves every NUM_REQ configuration.
  localparam int ID_W = $clog2(MAX_NUM_REQ);

  // DCT basis rows scaled by 128, coefficient n=0 in the top byte.
  localparam logic [63:0] COEF_ROM_ROWS [8] = '{
    64'h5B5B5B5B5B5B5B5B,
    64'h7E6A4719E7B99682,
    64'h7631CF8A8ACF3176,
    64'h6AE782B9477E1996,
    64'h5BA5A55B5BA5A55B,
    64'h4782196A96E77EB9,
    64'h318A76CFCF768A31,
    64'h19B96A827E9647E7
  };

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  // (base + off) mod n, for base < n and off <= n.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input logic [ID_W:0]   off,
                                               input int unsigned     n);
    logic [ID_W+1:0] s;
    s = {2'b00, base} + {1'b0, off};
    if (s >= (ID_W+2)'(n)) s = s - (ID_W+2)'(n);
    return ID_W'(s);
  endfunction

endpackage

// File: rtl/coef_rom_arbiter_if.sv
// Requester and ROM-port bundle for the coefficient ROM arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_ready on requests; responses are never stalled.
interface coef_rom_arbiter_if
  import coef_rom_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         rom_addr1;
  logic [ADDR_W-1:0]         rom_addr2;
  logic [DATA_W-1:0]         rom_dout1;
  logic [DATA_W-1:0]         rom_dout2;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ*DATA_W-1:0] rsp_data;

  // Requesters plus the ROM as seen from outside the arbiter.
  modport master (
    output req_valid, req_addr, rom_dout1, rom_dout2,
    input  req_ready, rom_addr1, rom_addr2, rsp_valid, rsp_data
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_addr, rom_dout1, rom_dout2,
    output req_ready, rom_addr1, rom_addr2, rsp_valid, rsp_data
  );

endinterface

// File: rtl/coef_rom_arbiter_rr_pick2.sv
// Two-winner rotating picker: first two set requests at or after ptr.
// Latency: purely combinational.
// Backpressure: none; losers simply get no grant this cycle.
module rr_pick2
  import coef_rom_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt1,
  output logic [NUM_REQ-1:0] gnt2,
  output logic               vld1,
  output logic               vld2,
  output logic [ID_W-1:0]    idx1,
  output logic [ID_W-1:0]    idx2
);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W:0]      off1;
  logic [ID_W:0]      off2;

  // Rotate so the pointer sits at bit 0, then take the two lowest set bits.
  always_comb begin
    rot  = NUM_REQ'({req, req} >> ptr);
    vld1 = 1'b0;
    vld2 = 1'b0;
    off1 = '0;
    off2 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rot[k]) begin
        if (!vld1) begin
          vld1 = 1'b1;
          off1 = (ID_W+1)'(k);
        end else if (!vld2) begin
          vld2 = 1'b1;
          off2 = (ID_W+1)'(k);
        end
      end
    end
  end

  // Map rotated offsets back to requester indices and one-hot grants.
  always_comb begin
    idx1 = wrap_add(ptr, off1, NUM_REQ);
    idx2 = wrap_add(ptr, off2, NUM_REQ);
    gnt1 = '0;
    gnt2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt1[i] = vld1 && (idx1 == ID_W'(i));
      gnt2[i] = vld2 && (idx2 == ID_W'(i));
    end
  end

endmodule

// File: rtl/coef_rom_arbiter.sv
// Shares the two ROM read ports among NUM_REQ requesters, two grants/cycle.
// Latency: accept in cycle T -> rsp_valid pulse in cycle T+ROM_LAT+1.
// Backpressure: req_ready per requester; responses cannot be stalled.
// Build option COEF_ARB_FIXED_PRIO_EN: fixed priority, lowest index first.
module coef_rom_arbiter
  import coef_rom_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic               clk,
  input  logic               rst,
  coef_rom_arbiter_if.slave  bus
);

  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] gnt1;
  logic [NUM_REQ-1:0] gnt2;
  logic               vld1;
  logic               vld2;
  logic [ID_W-1:0]    idx1;
  logic [ID_W-1:0]    idx2;
  logic [ID_W-1:0]    ptr;

  // Nothing is granted while in reset, so no read can be launched then.
  assign req_eff = rst ? '0 : bus.req_valid;

  rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
    .req  (req_eff),
    .ptr  (ptr),
    .gnt1 (gnt1),
    .gnt2 (gnt2),
    .vld1 (vld1),
    .vld2 (vld2),
    .idx1 (idx1),
    .idx2 (idx2)
  );

  assign bus.req_ready = gnt1 | gnt2;

`ifdef COEF_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;

  // Move the scan start just past the last winner so it is served last next.
  always_comb begin
    ptr_d = ptr_q;
    if (vld2)      ptr_d = wrap_add(idx2, (ID_W+1)'(1), NUM_REQ);
    else if (vld1) ptr_d = wrap_add(idx1, (ID_W+1)'(1), NUM_REQ);
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  logic [ADDR_W-1:0] rom_addr1;
  logic [ADDR_W-1:0] rom_addr2;

  // Steer each winner's address onto its port; an idle port reads row 0.
  always_comb begin
    rom_addr1 = '0;
    rom_addr2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt1[i]) rom_addr1 = bus.req_addr[i*ADDR_W +: ADDR_W];
      if (gnt2[i]) rom_addr2 = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign bus.rom_addr1 = rom_addr1;
  assign bus.rom_addr2 = rom_addr2;

  tag_t tag1_q [ROM_LAT];
  tag_t tag1_d [ROM_LAT];
  tag_t tag2_q [ROM_LAT];
  tag_t tag2_d [ROM_LAT];

  // Tag shift registers track which requester owns each in-flight ROM read.
  always_comb begin
    tag1_d[0] = tag_t'{vld: vld1, id: idx1};
    tag2_d[0] = tag_t'{vld: vld2, id: idx2};
    for (int s = 1; s < ROM_LAT; s++) begin
      tag1_d[s] = tag1_q[s-1];
      tag2_d[s] = tag2_q[s-1];
    end
  end

  // Tag pipeline registers; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < ROM_LAT; s++) begin
        tag1_q[s] <= '0;
        tag2_q[s] <= '0;
      end
    end else begin
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
    end
  end

  tag_t tag1_out;
  tag_t tag2_out;

  assign tag1_out = tag1_q[ROM_LAT-1];
  assign tag2_out = tag2_q[ROM_LAT-1];

  logic [NUM_REQ-1:0]        rsp_valid_q;
  logic [NUM_REQ-1:0]        rsp_valid_d;
  logic [NUM_REQ*DATA_W-1:0] rsp_data_q;
  logic [NUM_REQ*DATA_W-1:0] rsp_data_d;

  // Capture returning rows for the owning requester; the two ports never
  // name the same owner because a requester wins at most once per cycle.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag1_out.vld && (tag1_out.id == ID_W'(i))) begin
        rsp_valid_d[i]                 = 1'b1;
        rsp_data_d[i*DATA_W +: DATA_W] = bus.rom_dout1;
      end
      if (tag2_out.vld && (tag2_out.id == ID_W'(i))) begin
        rsp_valid_d[i]                 = 1'b1;
        rsp_data_d[i*DATA_W +: DATA_W] = bus.rom_dout2;
      end
    end
  end

  // Response registers: valid is a single-cycle pulse, data is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_coef_rom_arbiter.sv
// Bench for coef_rom_arbiter: directed scenarios plus random traffic,
// checked each cycle against a transaction-level model with a two-stage ROM.
module tb_coef_rom_arbiter;
  import coef_rom_pkg::*;

  localparam int NR = 4;
  localparam int AW = 3;
  localparam int DW = 64;
  localparam int RL = 2;
  localparam int VW = NR * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coef_rom_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  coef_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Two-stage ROM: data appears two clock edges after the address.
  logic [DW-1:0] rom_p1;
  logic [DW-1:0] rom_p2;
  always @(posedge clk) begin
    rom_p1        <= COEF_ROM_ROWS[bus.rom_addr1];
    rom_p2        <= COEF_ROM_ROWS[bus.rom_addr2];
    bus.rom_dout1 <= rom_p1;
    bus.rom_dout2 <= rom_p2;
  end

  typedef struct {
    int due;
    int id;
    int addr;
  } pend_t;

  int            errors = 0;
  int            checks = 0;
  int            cyc    = 0;
  int            ptr_m  = 0;
  bit            cur_v  [NR];
  int            cur_a  [NR];
  int            gcount [NR];
  logic [DW-1:0] exp_data [NR];
  pend_t         pend [$];

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive requests, check outputs at the falling edge
  // against the model, then advance the model to the next cycle.
  task automatic tick();
    int            g [$];
    int            start;
    logic [NR-1:0] er;
    logic [NR-1:0] ev;
    logic [AW-1:0] ea1;
    logic [AW-1:0] ea2;
    logic [VW-1:0] ed;

    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]         = cur_v[i];
      bus.req_addr[i*AW +: AW] = AW'(cur_a[i]);
    end
    @(negedge clk);

    if (!rst) begin
`ifdef COEF_ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = ptr_m;
`endif
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (start + k) % NR;
        if (cur_v[i] && g.size() < 2) g.push_back(i);
      end
    end
    er  = '0;
    ea1 = '0;
    ea2 = '0;
    foreach (g[j]) er[g[j]] = 1'b1;
    if (g.size() > 0) ea1 = AW'(cur_a[g[0]]);
    if (g.size() > 1) ea2 = AW'(cur_a[g[1]]);
    chk("req_ready", VW'(bus.req_ready), VW'(er));
    chk("rom_addr1", VW'(bus.rom_addr1), VW'(ea1));
    chk("rom_addr2", VW'(bus.rom_addr2), VW'(ea2));

    ev = '0;
    for (int j = pend.size() - 1; j >= 0; j--) begin
      if (pend[j].due == cyc) begin
        ev[pend[j].id]       = 1'b1;
        exp_data[pend[j].id] = COEF_ROM_ROWS[pend[j].addr];
        pend.delete(j);
      end
    end
    for (int i = 0; i < NR; i++) ed[i*DW +: DW] = exp_data[i];
    chk("rsp_valid", VW'(bus.rsp_valid), VW'(ev));
    chk("rsp_data", bus.rsp_data, ed);

    foreach (g[j]) begin
      pend.push_back('{due: cyc + RL + 1, id: g[j], addr: cur_a[g[j]]});
      cur_v[g[j]] = 1'b0;
      gcount[g[j]]++;
    end
    if (g.size() > 0) ptr_m = (g[g.size()-1] + 1) % NR;
    if (rst) begin
      ptr_m = 0;
      pend.delete();
      for (int i = 0; i < NR; i++) exp_data[i] = '0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic req(input int i, input int a);
    cur_v[i] = 1'b1;
    cur_a[i] = a;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    for (int i = 0; i < NR; i++) begin
      cur_v[i]    = 1'b0;
      cur_a[i]    = 0;
      gcount[i]   = 0;
      exp_data[i] = '0;
    end
    @(posedge clk);
    #1;

    // Reset, then ten idle cycles.
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("idle_data", bus.rsp_data, '0);

    // Single read from requester 0, row 1.
    req(0, 1);
    repeat (4) tick();
    chk("single_row", VW'(bus.rsp_data[0 +: DW]), VW'(64'h7E6A4719E7B99682));

    // Dual grant from a fresh pointer.
    reset_tick();
    req(1, 4);
    req(2, 6);
    repeat (4) tick();
    chk("dual_row1", VW'(bus.rsp_data[1*DW +: DW]), VW'(64'h5BA5A55B5BA5A55B));
    chk("dual_row2", VW'(bus.rsp_data[2*DW +: DW]), VW'(64'h318A76CFCF768A31));

    // Fairness: everyone requests continuously for eight cycles.
    reset_tick();
    for (int i = 0; i < NR; i++) gcount[i] = 0;
    repeat (8) begin
      for (int i = 0; i < NR; i++) if (!cur_v[i]) req(i, int'($urandom_range(0, 7)));
      tick();
    end
`ifdef COEF_ARB_FIXED_PRIO_EN
    chk("fair_g0", VW'(gcount[0]), VW'(8));
    chk("fair_g1", VW'(gcount[1]), VW'(8));
    chk("fair_g2", VW'(gcount[2]), VW'(0));
    chk("fair_g3", VW'(gcount[3]), VW'(0));
`else
    chk("fair_g0", VW'(gcount[0]), VW'(4));
    chk("fair_g1", VW'(gcount[1]), VW'(4));
    chk("fair_g2", VW'(gcount[2]), VW'(4));
    chk("fair_g3", VW'(gcount[3]), VW'(4));
`endif
    for (int i = 0; i < NR; i++) cur_v[i] = 1'b0;
    repeat (4) tick();

    // Wrap: pointer to 3, then requesters 3 and 0, then 0 and 1.
    reset_tick();
    req(2, 3);
    tick();
    req(3, 5);
    req(0, 2);
    tick();
    req(0, 0);
    req(1, 7);
    tick();
    for (int i = 0; i < NR; i++) cur_v[i] = 1'b0;
    repeat (4) tick();

    // Reset one cycle after accepting a read: no response may appear.
    reset_tick();
    req(0, 7);
    tick();
    reset_tick();
    repeat (3) tick();
    chk("midflight_data", bus.rsp_data, '0);
    req(1, 3);
    req(0, 5);
    repeat (4) tick();

    // Random traffic with occasional resets.
    repeat (300) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NR; i++)
        if (!cur_v[i] && $urandom_range(0, 99) < 55) req(i, int'($urandom_range(0, 7)));
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < NR; i++) cur_v[i] = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
